add_sub_serial: RTL and testbench
=================================

# add_sub_serial

Parametrised serial adder/subtractor, the successor of the 8-bit bit-serial adder. Operands of WIDTH bits are processed DIGIT bits per clock, least-significant digit first. The block supports add and two's-complement subtract modes and reports carry-out and signed overflow. It sits next to the datapath as a low-area arithmetic unit driven by a start/done handshake, and it accepts a new operation directly from DONE so operations can run back-to-back.

## Interface
- WIDTH, 8, operand and result width; must be ≥ 2.
- DIGIT, 1, bits processed per ADD cycle; must be 1..WIDTH with WIDTH % DIGIT == 0.
- N (localparam), WIDTH/DIGIT, number of ADD cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  first operand; sampled with start.
- b  input  WIDTH  second operand; sampled with start.
- out  output  WIDTH  result, registered.
- cout  output  1  final carry (sub mode: 1 = no borrow), registered.
- ovf  output  1  signed overflow, registered.
- busy  output  1  high in LOAD and ADD.
- done  output  1  high in DONE.

## Operation
- States: IDLE, LOAD, ADD, DONE. Encoding is free.
- IDLE:
  - start=1 captures a_reg←a and b_reg←(sub ? ~b : b).
  - It also sets carry←sub, count←0, and clears out, cout and ovf.
  - Next state is LOAD. With start=0, IDLE holds and no register changes.
- LOAD: one dead cycle, with no register change except state. Next state is ADD unconditionally.
- ADD, each cycle:
  - Form {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
  - out←{s, out[WIDTH-1:DIGIT]}; a_reg and b_reg shift right by DIGIT; carry←c; count←count+1.
  - When count==N−1, the state goes to DONE and the same edge loads cout←c.
  - On that edge ovf←(a_reg[DIGIT-1]==b_reg[DIGIT-1]) && (s[DIGIT-1]!=a_reg[DIGIT-1]), using pre-shift values.
- DONE:
  - Results hold.
  - start=1 behaves exactly like start in IDLE: new capture, outputs cleared, next state LOAD.
  - start=0 holds DONE indefinitely.
- start, sub, a and b are ignored in LOAD and ADD. No queuing.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.
- count is $clog2(N) bits wide, minimum 1 bit.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, out=0, cout=0, ovf=0, busy=0, done=0, and a_reg, b_reg, carry and count all 0.
- Reset asserted mid-operation aborts immediately. After release the block is in IDLE and waits for start.
- Latency: start sampled at edge T leads to LOAD in cycle T+1, ADD in cycles T+2..T+1+N, and done=1 from cycle T+2+N.
  - DIGIT=1, WIDTH=8: done 10 cycles after start.
- busy and done are decoded from registered state, with no combinational path from inputs.
- out, cout and ovf are valid whenever done=1. Intermediate out values in ADD are partial and undefined for consumers.
- Back-to-back: start held high in DONE gives done low for exactly N+1 cycles between results.

## Test plan
- Reset/idle: rst_n low mid-run → all outputs 0 immediately, state IDLE. start=0 for 20 cycles after release → outputs stay 0.
- Add, WIDTH=8, DIGIT=1:
  - 0x5A+0x33 → out=0x8D, cout=0, ovf=1.
  - 0xFF+0x01 → out=0x00, cout=1, ovf=0.
  - In both cases done rises exactly 10 cycles after start.
- Subtract, WIDTH=8, DIGIT=1:
  - 0x10−0x20 → out=0xF0, cout=0, ovf=0.
  - 0x80−0x01 → out=0x7F, cout=1, ovf=1.
- Multi-bit digit, WIDTH=16, DIGIT=4: 0x1234+0xEDCC → out=0x0000, cout=1, ovf=0, done 6 cycles after start, busy high for exactly 5 cycles.
- Handshake:
  - start toggled during ADD with different operands → ignored, result unchanged.
  - start held high in DONE → new operands captured, out/cout/ovf cleared next cycle, second result correct after a further N+1 cycles.
- Random regression: 1000 random (a, b, sub) per {WIDTH, DIGIT} ∈ {(8,1), (8,2), (16,4), (12,3), (8,8)} → out, cout and ovf match a reference model.

Source files
------------

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per cycle, LSD first,
// driven by a start/done handshake with registered result, carry-out and signed overflow.
module add_sub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_out;
   logic                   r_carry;
   logic                   r_cout;
   logic                   r_ovf;
   logic [CW-1:0]          r_count;
   logic [DIGIT:0]         w_sum;
   logic [WIDTH+DIGIT-1:0] w_out_cat;
   logic                   w_last;
   logic                   w_capture;

   assign w_sum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
   // New digit enters at the top; the slice also covers DIGIT == WIDTH without an empty range.
   assign w_out_cat = {w_sum[DIGIT-1:0], r_out};
   assign w_last    = (r_count == CW'(N - 1));
   assign w_capture = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  w_next = S_ADD;
         S_ADD:   if (w_last) w_next = S_DONE;
         S_DONE:  if (start) w_next = S_LOAD;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= '0;
      end else if (w_capture) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= sub;
         r_count <= '0;
         r_out   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == S_ADD) begin
         r_out   <= w_out_cat[WIDTH+DIGIT-1:DIGIT];
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_carry <= w_sum[DIGIT];
         r_count <= r_count + CW'(1);
         if (w_last) begin
            r_cout <= w_sum[DIGIT];
            r_ovf  <= (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_sum[DIGIT-1] != r_a[DIGIT-1]);
         end
      end
   end

   assign out  = r_out;
   assign cout = r_cout;
   assign ovf  = r_ovf;
   assign busy = (r_state == S_LOAD) || (r_state == S_ADD);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: five parameterisations side by side, scoreboard of model results
// popped when done rises, plus latency, busy-length, reset and handshake checks.
module tb_add_sub_serial;

   function automatic int wof(input int i);
      case (i)
         0: return 8;
         1: return 8;
         2: return 16;
         3: return 12;
         default: return 8;
      endcase
   endfunction

   function automatic int dof(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 4;
         3: return 3;
         default: return 8;
      endcase
   endfunction

   typedef struct {
      int          idx;
      logic [15:0] out;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start_v;
   logic [4:0]  sub_v;
   logic [4:0]  cout_v;
   logic [4:0]  ovf_v;
   logic [4:0]  busy_v;
   logic [4:0]  done_v;
   logic [15:0] a_v   [5];
   logic [15:0] b_v   [5];
   logic [15:0] out_v [5];

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] obs_out;
   logic        obs_cout;
   logic        obs_ovf;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int W = wof(g);
      localparam int D = dof(g);
      logic [W-1:0] w_out;

      add_sub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .start (start_v[g]),
         .sub   (sub_v[g]),
         .a     (a_v[g][W-1:0]),
         .b     (b_v[g][W-1:0]),
         .out   (w_out),
         .cout  (cout_v[g]),
         .ovf   (ovf_v[g]),
         .busy  (busy_v[g]),
         .done  (done_v[g])
      );

      assign out_v[g] = 16'(w_out);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input int idx, input logic [15:0] a, input logic [15:0] b,
                                  input logic s);
      int          w;
      logic [16:0] m;
      logic [16:0] be;
      logic [16:0] sum;
      exp_t        e;
      w      = wof(idx);
      m      = (17'd1 << w) - 17'd1;
      be     = {1'b0, (s ? ~b : b)} & m;
      sum    = ({1'b0, a} & m) + be + {16'd0, s};
      e.idx  = idx;
      e.out  = sum[15:0] & m[15:0];
      e.cout = sum[w];
      e.ovf  = (a[w-1] == be[w-1]) && (sum[w-1] != a[w-1]);
      return e;
   endfunction

   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input bit disturb);
      int   n;
      int   lat;
      int   busy_n;
      exp_t e;
      n = wof(idx) / dof(idx);
      @(negedge clk);
      a_v[idx]     = a;
      b_v[idx]     = b;
      sub_v[idx]   = s;
      start_v[idx] = 1'b1;
      exp_q.push_back(model(idx, a, b, s));
      @(negedge clk);
      start_v[idx] = 1'b0;
      lat    = 1;
      busy_n = 0;
      check("cleared_after_start", {14'd0, out_v[idx], cout_v[idx], ovf_v[idx]}, 32'd0);
      while (!done_v[idx] && lat < 64) begin
         if (busy_v[idx]) busy_n++;
         if (disturb && lat == 3) begin
            start_v[idx] = 1'b1;
            a_v[idx]     = ~a;
            b_v[idx]     = a ^ 16'h5a5a;
            sub_v[idx]   = ~s;
         end else begin
            start_v[idx] = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start_v[idx] = 1'b0;
      check("done_latency", lat, n + 2);
      check("busy_cycles", busy_n, n + 1);
      e        = exp_q.pop_front();
      obs_out  = out_v[idx];
      obs_cout = cout_v[idx];
      obs_ovf  = ovf_v[idx];
      check("sb_out", obs_out, e.out);
      check("sb_cout", obs_cout, e.cout);
      check("sb_ovf", obs_ovf, e.ovf);
   endtask

   task automatic check_res(input string tag, input logic [15:0] o, input logic c, input logic v);
      check({tag, "_out"}, obs_out, o);
      check({tag, "_cout"}, obs_cout, c);
      check({tag, "_ovf"}, obs_ovf, v);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_v = '0;
      sub_v   = '0;
      for (int i = 0; i < 5; i++) begin
         a_v[i] = '0;
         b_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++)
         check("reset_outputs", {13'd0, out_v[i], cout_v[i], ovf_v[i], busy_v[i], done_v[i]}, 32'd0);
      rst_n = 1'b1;

      // Abort mid-operation: partial result of 0xFF+0x00 is non-zero before reset hits.
      @(negedge clk);
      a_v[0] = 16'h00FF; b_v[0] = 16'h0000; sub_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_abort", busy_v[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {13'd0, out_v[0], cout_v[0], ovf_v[0], busy_v[0], done_v[0]}, 32'd0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_after_abort", {13'd0, out_v[0], cout_v[0], ovf_v[0], busy_v[0], done_v[0]}, 32'd0);
      end

      run_op(0, 16'h005A, 16'h0033, 1'b0, 1'b0);
      check_res("add_5a_33", 16'h008D, 1'b0, 1'b1);
      run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      check_res("add_ff_01", 16'h0000, 1'b1, 1'b0);
      run_op(0, 16'h0010, 16'h0020, 1'b1, 1'b0);
      check_res("sub_10_20", 16'h00F0, 1'b0, 1'b0);
      run_op(0, 16'h0080, 16'h0001, 1'b1, 1'b0);
      check_res("sub_80_01", 16'h007F, 1'b1, 1'b1);
      run_op(2, 16'h1234, 16'hEDCC, 1'b0, 1'b0);
      check_res("add16_1234_edcc", 16'h0000, 1'b1, 1'b0);

      // start pulsed mid-ADD with other operands must not disturb the result.
      run_op(0, 16'h0037, 16'h0049, 1'b0, 1'b1);
      check_res("ignore_start_w8", 16'h0080, 1'b0, 1'b1);
      run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
      check_res("ignore_start_w16", 16'h8000, 1'b0, 1'b1);

      // Back-to-back from DONE: each run_op restarts straight out of the previous DONE.
      run_op(3, 16'h0800, 16'h0001, 1'b1, 1'b0);
      check_res("b2b_first", 16'h07FF, 1'b1, 1'b1);
      run_op(3, 16'h0ABC, 16'h0123, 1'b0, 1'b0);
      check_res("b2b_second", 16'h0BDF, 1'b0, 1'b0);
      run_op(4, 16'h007F, 16'h0001, 1'b0, 1'b0);
      check_res("w8d8_add", 16'h0080, 1'b0, 1'b1);

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 1000; k++)
            run_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
